// File: rtl/sum_pkg.sv
// Shared types and helpers for the summing-thread stream source.
// Holds the FSM state type, datapath width and the 7-segment lookup.
package sum_pkg;

    localparam int SUM_W      = 8;
    localparam int FILTER_LEN = 16;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE,
        CHECK
    } src_state_t;

    // Segment order is {g,f,e,d,c,b,a}; a lit segment is driven low.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Nibble to active-low seven-segment decoder for one HEX digit.
module hex7seg
    import sum_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = seg_decode(i_nibble);

endmodule

// File: rtl/sum_stream_src.sv
// Streams stored operands to the go_l/inA summing thread, keeps a reference sum,
// waits for done and compares the downstream-latched result against it.
module sum_stream_src
    import sum_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     i_start_l,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [SUM_W-1:0]         i_wr_data,
    input  logic                     i_done,
    input  logic [SUM_W-1:0]         i_result,
    output logic                     o_go_l,
    output logic [SUM_W-1:0]         o_value_out,
    output logic [SUM_W-1:0]         o_exp_sum,
    output logic                     o_match,
    output logic                     o_timeout,
    output logic                     o_busy,
    output logic [6:0]               o_hex1,
    output logic [6:0]               o_hex0
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam int FW = $clog2(FILTER_LEN);

    logic [SUM_W-1:0] r_mem [DEPTH];

    logic [1:0]    r_sync;
    logic [FW-1:0] r_lowCnt;
    logic          r_armed;
    logic          r_goEvt;

    src_state_t    r_state;
    logic [AW-1:0] r_idx;
    logic [CW-1:0] r_waitCnt;

    // The table is frozen while a sequence is running so the reference sum stays coherent.
    always_ff @(posedge clk) begin
        if (i_wr_en && !o_busy) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // A press must read low for FILTER_LEN consecutive synced samples; r_armed limits it to one event.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_sync   <= 2'b11;
            r_lowCnt <= '0;
            r_armed  <= 1'b1;
            r_goEvt  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_start_l};
            r_goEvt <= 1'b0;
            if (r_sync[1]) begin
                r_lowCnt <= '0;
                r_armed  <= 1'b1;
            end else if (r_lowCnt != FW'(FILTER_LEN - 1)) begin
                r_lowCnt <= r_lowCnt + 1'b1;
            end else if (r_armed) begin
                r_goEvt <= 1'b1;
                r_armed <= 1'b0;
            end
        end
    end

    // o_value_out always holds the operand on the bus this cycle, so the sum and the
    // terminator test both key off it.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_waitCnt   <= '0;
            o_go_l      <= 1'b1;
            o_value_out <= '0;
            o_exp_sum   <= '0;
            o_match     <= 1'b0;
            o_timeout   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_goEvt) begin
                        r_state     <= SEND;
                        r_idx       <= '0;
                        o_go_l      <= 1'b0;
                        o_value_out <= r_mem[0];
                        o_exp_sum   <= '0;
                        o_match     <= 1'b0;
                        o_timeout   <= 1'b0;
                        o_busy      <= 1'b1;
                    end
                end
                SEND: begin
                    o_exp_sum <= o_exp_sum + o_value_out;
                    if (o_value_out == '0) begin
                        o_go_l    <= 1'b1;
                        r_waitCnt <= '0;
                        r_state   <= WAIT_DONE;
                    end else if (r_idx == AW'(DEPTH - 1)) begin
                        o_value_out <= '0;
                    end else begin
                        r_idx       <= r_idx + 1'b1;
                        o_value_out <= r_mem[r_idx + 1'b1];
                    end
                end
                WAIT_DONE: begin
                    if (i_done) begin
                        r_state <= CHECK;
                    end else if (r_waitCnt == CW'(TIMEOUT - 1)) begin
                        o_timeout <= 1'b1;
                        o_busy    <= 1'b0;
                        o_match   <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                CHECK: begin
                    o_match <= (i_result == o_exp_sum);
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    hex7seg u_hex1 (
        .i_nibble(o_exp_sum[7:4]),
        .o_seg   (o_hex1)
    );

    hex7seg u_hex0 (
        .i_nibble(o_exp_sum[3:0]),
        .o_seg   (o_hex0)
    );

endmodule

// File: tb/tb_sum_stream_src.sv
// Directed bench for sum_stream_src: operand streaming, wrap, terminator insertion,
// timeout, start debouncing, async reset and the match/HEX outputs.
module tb_sum_stream_src;

    logic       clk;
    logic       rstL;
    logic       startL;
    logic       wrEn;
    logic [3:0] wrAddr;
    logic [7:0] wrData;
    logic       done;
    logic [7:0] result;
    logic       goL;
    logic [7:0] valueOut;
    logic [7:0] expSum;
    logic       match;
    logic       timeoutFlag;
    logic       busy;
    logic [6:0] hex1;
    logic [6:0] hex0;

    int         checks = 0;
    int         errors = 0;
    int         burstLen;
    logic [7:0] burstVals [64];
    int         burstCount = 0;

    sum_stream_src #(.DEPTH(16), .TIMEOUT(1024)) dut (
        .clk        (clk),
        .rst_l      (rstL),
        .i_start_l  (startL),
        .i_wr_en    (wrEn),
        .i_wr_addr  (wrAddr),
        .i_wr_data  (wrData),
        .i_done     (done),
        .i_result   (result),
        .o_go_l     (goL),
        .o_value_out(valueOut),
        .o_exp_sum  (expSum),
        .o_match    (match),
        .o_timeout  (timeoutFlag),
        .o_busy     (busy),
        .o_hex1     (hex1),
        .o_hex0     (hex0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge goL) burstCount++;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (observed hang, expected finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Writes one operand slot while idle.
    task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data);
        wrEn   = 1'b1;
        wrAddr = addr;
        wrData = data;
        @(negedge clk);
        wrEn   = 1'b0;
    endtask

    task automatic holdStart(input logic level, input int cycles);
        startL = level;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic captureBurst(input int maxWait);
        int waited = 0;
        burstLen = 0;
        while (goL !== 1'b0 && waited < maxWait) begin
            @(negedge clk);
            waited++;
        end
        if (goL !== 1'b0) begin
            checkOutput("burst_start", {31'd0, goL}, 32'd0);
            return;
        end
        while (goL === 1'b0 && burstLen < 40) begin
            burstVals[burstLen] = valueOut;
            burstLen++;
            @(negedge clk);
        end
    endtask

    task automatic pulseDone(input logic [7:0] value);
        @(negedge clk);
        done   = 1'b1;
        result = value;
        @(negedge clk);
        done   = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int waited;
        int countBefore;
        logic [7:0] seq1 [4];
        seq1[0] = 8'd5; seq1[1] = 8'd3; seq1[2] = 8'd2; seq1[3] = 8'd0;

        rstL   = 1'b0;
        startL = 1'b1;
        wrEn   = 1'b0;
        wrAddr = '0;
        wrData = '0;
        done   = 1'b0;
        result = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_go_l", goL, 1);
        checkOutput("rst_value", valueOut, 0);
        checkOutput("rst_exp_sum", expSum, 0);
        checkOutput("rst_match", match, 0);
        checkOutput("rst_timeout", timeoutFlag, 0);
        checkOutput("rst_busy", busy, 0);
        rstL = 1'b1;
        @(negedge clk);

        // Basic four-operand list.
        for (int i = 0; i < 4; i++) applyStimulus(4'(i), seq1[i]);
        startL = 1'b0;
        captureBurst(64);
        startL = 1'b1;
        checkOutput("t1_len", burstLen, 4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("t1_val%0d", i), burstVals[i], seq1[i]);
        checkOutput("t1_exp_sum", expSum, 8'h0A);
        checkOutput("t1_busy", busy, 1);
        pulseDone(8'h0A);
        checkOutput("t1_match", match, 1);
        checkOutput("t1_busy_after", busy, 0);
        checkOutput("t1_hex1", hex1, 7'h40);
        checkOutput("t1_hex0", hex0, 7'h08);

        // Modulo-256 wrap, then a stray done while idle.
        applyStimulus(4'd0, 8'hFF);
        applyStimulus(4'd1, 8'h02);
        applyStimulus(4'd2, 8'h00);
        holdStart(1'b1, 4);
        startL = 1'b0;
        captureBurst(64);
        startL = 1'b1;
        checkOutput("t2_len", burstLen, 3);
        checkOutput("t2_val0", burstVals[0], 8'hFF);
        checkOutput("t2_val1", burstVals[1], 8'h02);
        checkOutput("t2_val2", burstVals[2], 8'h00);
        checkOutput("t2_exp_sum", expSum, 8'h01);
        pulseDone(8'h01);
        checkOutput("t2_match", match, 1);
        pulseDone(8'h55);
        checkOutput("t2_stray_done_match", match, 1);
        checkOutput("t2_stray_done_busy", busy, 0);
        holdStart(1'b1, 4);
        startL = 1'b0;
        captureBurst(64);
        startL = 1'b1;
        checkOutput("t2b_exp_sum", expSum, 8'h01);
        pulseDone(8'h02);
        checkOutput("t2b_match", match, 0);

        // Full table without a terminator, then let it time out.
        for (int i = 0; i < 16; i++) applyStimulus(4'(i), 8'h01);
        holdStart(1'b1, 4);
        startL = 1'b0;
        captureBurst(64);
        startL = 1'b1;
        checkOutput("t3_len", burstLen, 17);
        for (int i = 0; i < 16; i++) checkOutput($sformatf("t3_val%0d", i), burstVals[i], 8'h01);
        checkOutput("t3_val16", burstVals[16], 8'h00);
        checkOutput("t3_exp_sum", expSum, 8'h10);
        checkOutput("t3_hex1", hex1, 7'h79);
        checkOutput("t3_hex0", hex0, 7'h40);
        waited = 0;
        while (busy === 1'b1 && waited < 1200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("t4_timeout_cycles", waited, 1024);
        checkOutput("t4_timeout", timeoutFlag, 1);
        checkOutput("t4_busy", busy, 0);
        checkOutput("t4_match", match, 0);

        // Bouncing button, then a repeat press while busy.
        applyStimulus(4'd0, 8'h07);
        applyStimulus(4'd1, 8'h00);
        countBefore = burstCount;
        holdStart(1'b0, 5);
        holdStart(1'b1, 3);
        holdStart(1'b0, 8);
        holdStart(1'b1, 2);
        holdStart(1'b0, 10);
        holdStart(1'b1, 20);
        checkOutput("t5_glitch_bursts", burstCount - countBefore, 0);
        checkOutput("t5_glitch_busy", busy, 0);
        startL = 1'b0;
        captureBurst(64);
        checkOutput("t5_len", burstLen, 2);
        checkOutput("t5_val0", burstVals[0], 8'h07);
        holdStart(1'b1, 3);
        holdStart(1'b0, 30);
        holdStart(1'b1, 5);
        checkOutput("t5_busy_during", busy, 1);
        pulseDone(8'h07);
        checkOutput("t5_match", match, 1);
        holdStart(1'b1, 25);
        checkOutput("t5_bursts", burstCount - countBefore, 1);
        checkOutput("t5_busy_after", busy, 0);

        // Asynchronous reset in the middle of SEND.
        applyStimulus(4'd0, 8'h01);
        applyStimulus(4'd1, 8'h01);
        startL = 1'b0;
        waited = 0;
        while (goL !== 1'b0 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("t6_send_started", goL, 0);
        repeat (2) @(negedge clk);
        checkOutput("t6_busy_before", busy, 1);
        #2;
        rstL   = 1'b0;
        startL = 1'b1;
        #1;
        checkOutput("t6_go_l", goL, 1);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_exp_sum", expSum, 0);
        checkOutput("t6_value", valueOut, 0);
        @(negedge clk);
        rstL = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("t6_idle_go_l", goL, 1);
        checkOutput("t6_idle_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
